// File: rtl/sv32_arb_pkg.sv
// sv32_arb_pkg: shared FSM state and grant encodings for the Sv32 MMU arbiter.
package sv32_arb_pkg;
    typedef enum logic [2:0] {IDLE, GRANT_I, GRANT_D, FAULT_WAIT, FLUSH} arb_state_e;
    typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} grant_e;
endpackage

// File: rtl/sv32_arb_pick.sv
// sv32_arb_pick: combinational I/D picker; ties go to D, or alternate when
// SV32_ARB_ROUND_ROBIN_EN is defined.
module sv32_arb_pick
    import sv32_arb_pkg::*;
(
    input  logic   i_valid,
    input  logic   d_valid,
`ifdef SV32_ARB_ROUND_ROBIN_EN
    input  grant_e last_grant,
`endif
    output grant_e grant
);
    always_comb begin
`ifdef SV32_ARB_ROUND_ROBIN_EN
        grant = (i_valid & d_valid) ? ((last_grant == GNT_I) ? GNT_D : GNT_I)
                                    : (i_valid ? GNT_I : GNT_D);
`else
        grant = (i_valid & ~d_valid) ? GNT_I : GNT_D;
`endif
    end
endmodule

// File: rtl/sv32_mmu_arbiter.sv
// sv32_mmu_arbiter: arbitrates I-fetch and data requesters onto one Sv32 MMU port
// and sequences sfence.vma TLB flushes; SV32_ARB_ROUND_ROBIN_EN enables fair ties.
module sv32_mmu_arbiter
    import sv32_arb_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    output logic        i_fault,
    input  logic        d_valid,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_fault,
    output logic        mmu_valid,
    output logic        mmu_is_instruction,
    output logic [3:0]  mmu_wstrb,
    output logic [31:0] mmu_addr,
    output logic [31:0] mmu_wdata,
    input  logic        mmu_ready,
    input  logic [31:0] mmu_rdata,
    input  logic        mmu_page_fault,
    input  logic        flush_req,
    output logic        mmu_tlb_flush,
    output logic        flush_done,
    output logic        fault_is_instr
);
    localparam logic [3:0] FC = 4'(FLUSH_CYCLES);

    arb_state_e  r_state;
    logic        r_pend;
    logic [3:0]  r_cnt;
    logic        r_fault_is_instr;
    grant_e      w_pick;
    logic        w_gi;
    logic        w_gd;
`ifdef SV32_ARB_ROUND_ROBIN_EN
    grant_e      r_last;
`endif

    sv32_arb_pick u_pick (
        .i_valid    (i_valid),
        .d_valid    (d_valid),
`ifdef SV32_ARB_ROUND_ROBIN_EN
        .last_grant (r_last),
`endif
        .grant      (w_pick)
    );

    assign w_gi = (r_state == GRANT_I);
    assign w_gd = (r_state == GRANT_D);
    assign fault_is_instr = r_fault_is_instr;

    // A fault in the grant cycle suppresses valid and ready on the same cycle.
    always_comb begin
        mmu_valid          = w_gi ? (i_valid & ~mmu_page_fault) : w_gd ? (d_valid & ~mmu_page_fault) : 1'b0;
        mmu_is_instruction = w_gi;
        mmu_wstrb          = w_gd ? d_wstrb : '0;
        mmu_addr           = w_gi ? i_addr : w_gd ? d_addr : '0;
        mmu_wdata          = w_gd ? d_wdata : '0;
        i_ready            = w_gi & mmu_ready & ~mmu_page_fault;
        d_ready            = w_gd & mmu_ready & ~mmu_page_fault;
        i_rdata            = w_gi ? mmu_rdata : '0;
        d_rdata            = w_gd ? mmu_rdata : '0;
        i_fault            = w_gi & mmu_page_fault;
        d_fault            = w_gd & mmu_page_fault;
        mmu_tlb_flush      = (r_state == FLUSH) && (r_cnt != FC);
        flush_done         = (r_state == FLUSH) && (r_cnt == FC);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= IDLE;
            r_pend           <= 1'b0;
            r_cnt            <= '0;
            r_fault_is_instr <= 1'b0;
`ifdef SV32_ARB_ROUND_ROBIN_EN
            r_last           <= GNT_D;
`endif
        end else begin
            r_pend <= r_pend | flush_req;
            case (r_state)
                IDLE: begin
                    if (r_pend | flush_req) begin
                        r_state <= FLUSH;
                        r_pend  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (i_valid | d_valid) begin
                        r_state <= (w_pick == GNT_I) ? GRANT_I : GRANT_D;
`ifdef SV32_ARB_ROUND_ROBIN_EN
                        r_last  <= w_pick;
`endif
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (mmu_page_fault) begin
                        r_fault_is_instr <= w_gi;
                        r_state          <= FAULT_WAIT;
                    end else if (mmu_ready) begin
                        r_state <= IDLE;
                    end
                end
                FAULT_WAIT: if (!mmu_page_fault) r_state <= IDLE;
                FLUSH: begin
                    if (r_cnt == FC) r_state <= IDLE;
                    else r_cnt <= r_cnt + 4'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sv32_mmu_arbiter.sv
// tb_sv32_mmu_arbiter: directed bench for sv32_mmu_arbiter with FLUSH_CYCLES=3;
// tie-order expectations follow SV32_ARB_ROUND_ROBIN_EN.
module tb_sv32_mmu_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid = 1'b0, d_valid = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mmu_rdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        mmu_ready = 1'b0, mmu_page_fault = 1'b0, flush_req = 1'b0;
    logic        i_ready, i_fault, d_ready, d_fault, mmu_valid, mmu_is_instruction;
    logic [31:0] i_rdata, d_rdata, mmu_addr, mmu_wdata;
    logic [3:0]  mmu_wstrb;
    logic        mmu_tlb_flush, flush_done, fault_is_instr;
    int          n_pass = 0, n_tot = 0;

    sv32_mmu_arbiter #(.FLUSH_CYCLES(3)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_fault(i_fault),
        .d_valid(d_valid), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_fault(d_fault),
        .mmu_valid(mmu_valid), .mmu_is_instruction(mmu_is_instruction), .mmu_wstrb(mmu_wstrb),
        .mmu_addr(mmu_addr), .mmu_wdata(mmu_wdata), .mmu_ready(mmu_ready), .mmu_rdata(mmu_rdata),
        .mmu_page_fault(mmu_page_fault), .flush_req(flush_req), .mmu_tlb_flush(mmu_tlb_flush),
        .flush_done(flush_done), .fault_is_instr(fault_is_instr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic serve(input logic [31:0] rdata, output logic is_i);
        logic ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mmu_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("serve_grant", ok, 1);
        is_i = mmu_is_instruction;
        mmu_ready = 1'b1;
        mmu_rdata = rdata;
        #1;
        chk("serve_ready", is_i ? i_ready : d_ready, 1);
        tick();
        mmu_ready = 1'b0;
        mmu_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       is_i;
        logic       seen;
        logic [5:0] e_fl = 6'b000111, e_dn = 6'b001000, e_mv = 6'b100000;
        @(negedge clk);
        chk("rst_valid", mmu_valid, 0);
        chk("rst_flush", mmu_tlb_flush, 0);
        chk("rst_fii", fault_is_instr, 0);
        chk("rst_addr", mmu_addr, 0);
        tick();
        reset = 1'b0;

        // single instruction fetch, ready on third valid cycle
        i_valid = 1'b1;
        i_addr  = 32'h8000_0000;
        @(negedge clk);
        chk("if_idle_valid", mmu_valid, 0);
        tick();
        @(negedge clk);
        chk("if_valid1", mmu_valid, 1);
        chk("if_is_instr", mmu_is_instruction, 1);
        chk("if_addr", mmu_addr, 32'h8000_0000);
        chk("if_wstrb", mmu_wstrb, 0);
        chk("if_ready_early", i_ready, 0);
        tick();
        @(negedge clk);
        chk("if_valid2", mmu_valid, 1);
        tick();
        @(negedge clk);
        chk("if_valid3", mmu_valid, 1);
        mmu_ready = 1'b1;
        mmu_rdata = 32'h0000_0013;
        #1;
        chk("if_ready", i_ready, 1);
        chk("if_rdata", i_rdata, 32'h0000_0013);
        chk("if_d_ready", d_ready, 0);
        tick();
        mmu_ready = 1'b0;
        mmu_rdata = '0;
        i_valid = 1'b0;
        @(negedge clk);
        chk("if_ready_after", i_ready, 0);
        chk("if_idle_after", mmu_valid, 0);

        // tie order from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        i_valid = 1'b1;
        d_valid = 1'b1;
`ifdef SV32_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 8; k++) begin
            serve(32'(k), is_i);
            chk($sformatf("rr_order%0d", k), is_i, (k % 2 == 0) ? 1 : 0);
        end
        i_valid = 1'b0;
        d_valid = 1'b0;
`else
        for (int k = 0; k < 4; k++) begin
            serve(32'(k), is_i);
            chk($sformatf("fix_d%0d", k), is_i, 0);
        end
        d_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            serve(32'(k), is_i);
            chk($sformatf("fix_i%0d", k), is_i, 1);
        end
        i_valid = 1'b0;
`endif

        // data store page fault held two cycles
        d_valid = 1'b1;
        d_wstrb = 4'hF;
        d_addr  = 32'hC000_1000;
        d_wdata = 32'hDEAD_BEEF;
        tick();
        @(negedge clk);
        chk("st_valid", mmu_valid, 1);
        chk("st_wstrb", mmu_wstrb, 4'hF);
        chk("st_addr", mmu_addr, 32'hC000_1000);
        chk("st_wdata", mmu_wdata, 32'hDEAD_BEEF);
        chk("st_is_instr", mmu_is_instruction, 0);
        mmu_page_fault = 1'b1;
        #1;
        chk("st_fault", d_fault, 1);
        chk("st_fault_valid", mmu_valid, 0);
        chk("st_fault_ready", d_ready, 0);
        tick();
        @(negedge clk);
        chk("st_fault_pulse", d_fault, 0);
        chk("st_fw_valid", mmu_valid, 0);
        chk("st_fii", fault_is_instr, 0);
        chk("st_fw_ready", d_ready, 0);
        mmu_page_fault = 1'b0;
        d_valid = 1'b0;
        d_wstrb = '0;
        tick();
        @(negedge clk);
        chk("st_idle_valid", mmu_valid, 0);
        chk("st_idle_ready", d_ready, 0);

        // instruction fault sets fault_is_instr
        i_valid = 1'b1;
        tick();
        @(negedge clk);
        mmu_page_fault = 1'b1;
        #1;
        chk("if_fault", i_fault, 1);
        chk("if_fault_ready", i_ready, 0);
        tick();
        mmu_page_fault = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        chk("if_fii", fault_is_instr, 1);
        chk("if_fault_pulse", i_fault, 0);
        tick();

        // flush requested mid data grant, instruction waiting behind it
        d_valid = 1'b1;
        tick();
        @(negedge clk);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        i_valid = 1'b1;
        @(negedge clk);
        chk("fl_no_early", mmu_tlb_flush, 0);
        mmu_ready = 1'b1;
        #1;
        chk("fl_d_ready", d_ready, 1);
        tick();
        mmu_ready = 1'b0;
        d_valid = 1'b0;
        @(negedge clk);
        chk("fl_idle", mmu_tlb_flush, 0);
        tick();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("fl_tlb%0d", k), mmu_tlb_flush, e_fl[k]);
            chk($sformatf("fl_done%0d", k), flush_done, e_dn[k]);
            chk($sformatf("fl_mv%0d", k), mmu_valid, e_mv[k]);
            if (k == 5) begin
                chk("fl_i_grant", mmu_is_instruction, 1);
                mmu_ready = 1'b1;
            end
            tick();
        end
        mmu_ready = 1'b0;
        i_valid = 1'b0;

        // reset in the second flush cycle
        flush_req = 1'b1;
        @(negedge clk);
        chk("rf_idle", mmu_tlb_flush, 0);
        tick();
        flush_req = 1'b0;
        @(negedge clk);
        chk("rf_c1", mmu_tlb_flush, 1);
        tick();
        @(negedge clk);
        chk("rf_c2", mmu_tlb_flush, 1);
        reset = 1'b1;
        #1;
        chk("rf_async", mmu_tlb_flush, 0);
        chk("rf_async_done", flush_done, 0);
        tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen = seen | flush_done | mmu_tlb_flush;
            tick();
        end
        chk("rf_no_done", seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/sv32_mmu_arbiter.md
SV32_MMU_ARBITER -- requirements
Module: sv32_mmu_arbiter

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, meaning the number of cycles mmu_tlb_flush is held high per flush (legal range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports i_valid in 1, i_addr in 32, i_ready out 1, i_rdata out 32, i_fault out 1 for the instruction-fetch requester.
REQ-005 SHALL have ports d_valid in 1, d_wstrb in 4, d_addr in 32, d_wdata in 32, d_ready out 1, d_rdata out 32, d_fault out 1 for the data requester.
REQ-006 SHALL have ports mmu_valid out 1, mmu_is_instruction out 1, mmu_wstrb out 4, mmu_addr out 32, mmu_wdata out 32, mmu_ready in 1, mmu_rdata in 32, mmu_page_fault in 1 toward the Sv32 MMU CPU port.
REQ-007 SHALL have ports flush_req in 1 (sfence.vma request pulse), mmu_tlb_flush out 1, flush_done out 1 (one-cycle completion pulse).
REQ-008 SHALL have port fault_is_instr out 1, which is registered and reports the requester of the most recent page fault.

Function
REQ-009 SHALL implement the states IDLE, GRANT_I, GRANT_D, FAULT_WAIT and FLUSH, held in a state register.
REQ-010 In IDLE with flush pending, SHALL go to FLUSH; flush takes priority over both requesters.
REQ-011 In IDLE with no flush pending, SHALL go to GRANT_I or GRANT_D per the pick rule in REQ-022; with no request it SHALL stay in IDLE.
REQ-012 SHALL drive mmu_valid=0 in IDLE, so the first mmu_valid comes one cycle after the request is seen.
REQ-013 In GRANT_x, SHALL drive mmu_valid=x_valid, pass the x address/wstrb/wdata fields through, and set mmu_is_instruction=1 for I, or mmu_wstrb=d_wstrb for D; I-side mmu_wstrb is 0 and mmu_wdata is 0.
REQ-014 In GRANT_x, SHALL drive x_ready=mmu_ready and x_rdata=mmu_rdata; the other requester's ready is 0 and its rdata is 0.
REQ-015 In GRANT_x, mmu_ready=1 SHALL return the block to IDLE in the same cycle-edge; back-to-back grants are therefore separated by one IDLE cycle.
REQ-016 The grant SHALL be held until mmu_ready or mmu_page_fault; deasserting x_valid mid-grant is illegal and is not recovered from.
REQ-017 In GRANT_x, mmu_page_fault=1 SHALL pulse x_fault for exactly one cycle, register fault_is_instr, force mmu_valid=0 and enter FAULT_WAIT; x_ready stays 0.
REQ-018 FAULT_WAIT SHALL hold mmu_valid=0 and return to IDLE on the first cycle mmu_page_fault=0.
REQ-019 flush_req SHALL set a sticky pending bit in any state; a flush_req arriving during FLUSH is re-latched for a second flush.
REQ-020 FLUSH SHALL drive mmu_tlb_flush=1 for exactly FLUSH_CYCLES cycles using a 4-bit counter, then pulse flush_done once and return to IDLE.
REQ-021 A flush_req during GRANT_x SHALL wait for the current transaction to complete (ready or fault) before flushing.

Reset
REQ-022 The pick rule is defined under Configuration; last_grant SHALL reset to D so that the first tie goes to I.
REQ-023 Asserting reset SHALL immediately force: state IDLE, flush pending 0, counter 0, fault_is_instr 0, and all outputs 0, including mid-grant or mid-flush.

Configuration
REQ-024 With SV32_ARB_ROUND_ROBIN_EN defined, a tie SHALL grant the requester not in last_grant, and last_grant SHALL update on every grant.
REQ-025 Without SV32_ARB_ROUND_ROBIN_EN, a tie SHALL always grant D, and last_grant SHALL be absent.

Structure
REQ-026 The state encoding and the GRANT_I/GRANT_D encoding SHALL live in a shared package, sv32_arb_pkg.
REQ-027 SHALL contain one sub-module, sv32_arb_pick, a combinational picker taking (i_valid, d_valid, last_grant) and producing the grant.

Verification
REQ-028 i_valid=1, addr 0x8000_0000; mmu_ready on the 3rd mmu_valid cycle -> mmu_is_instruction=1, i_ready high for 1 cycle, i_rdata=mmu_rdata=0x0000_0013.
REQ-029 i_valid and d_valid both high from reset, each served 4 times -> with the macro, grant order I,D,I,D,...; without it, D is served continuously while held, then I.
REQ-030 D store, d_wstrb=0xF, addr 0xC000_1000; mmu_page_fault=1 for 2 cycles -> d_fault pulses once, fault_is_instr=0, d_ready never 1, mmu_valid=0 until the fault clears, then IDLE.
REQ-031 flush_req pulsed mid D grant with FLUSH_CYCLES=3 -> after d_ready, mmu_tlb_flush high for exactly 3 cycles, then flush_done for 1 cycle, and a pending i_valid is granted only after that.
REQ-032 reset asserted during FLUSH cycle 2 -> mmu_tlb_flush=0 immediately; no flush_done follows reset release.
